// File: rtl/lsu_bus_ctrl.sv
// ============================================================================
// lsu_bus_ctrl : one-at-a-time load/store controller for a word-addressed
//                data bus. Define MISALIGN_TRAP_EN to trap misaligned H/W.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_low_addr,
  output logic [2:0]  rsp_size,
  output logic        rsp_err
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_bus  = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [1:0]      lat_low_q, lat_low_d;
  logic [2:0]      lat_size_q, lat_size_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_low_q, rsp_low_d;
  logic [2:0]      rsp_size_q, rsp_size_d;
  logic            rsp_err_q, rsp_err_d;

  logic            w_legal;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;

  always_comb begin
    w_legal = 1'b1;
    if (req_size[1:0] == 2'b11 || req_size == 3'b110) w_legal = 1'b0;
    if (req_we && req_size[2]) w_legal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (req_size[1:0] == 2'b01 && req_addr[1:0] == 2'b11) w_legal = 1'b0;
    if (req_size[1:0] == 2'b10 && req_addr[1:0] != 2'b00) w_legal = 1'b0;
`endif
  end

  // Halfword at offset 3 loses its upper lane through the 4-bit shift.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    if (req_size[1:0] == 2'b00) begin
      w_be    = 4'b0001 << req_addr[1:0];
      w_wdata = req_wdata << {req_addr[1:0], 3'b000};
    end else if (req_size[1:0] == 2'b01) begin
      w_be    = 4'b0011 << req_addr[1:0];
      w_wdata = req_wdata << {req_addr[1:0], 3'b000};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    lat_low_d   = lat_low_q;
    lat_size_d  = lat_size_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_low_d   = rsp_low_q;
    rsp_size_d  = rsp_size_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      c_idle: begin
        if (req_valid) begin
          if (w_legal) begin
            state_d     = c_bus;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = w_be;
            mem_wdata_d = w_wdata;
            lat_low_d   = req_addr[1:0];
            lat_size_d  = req_size;
          end else begin
            state_d     = c_resp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_low_d   = req_addr[1:0];
            rsp_size_d  = req_size;
          end
        end
      end
      c_bus: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (mem_ready || cnt_q == c_to_last) begin
          state_d     = c_resp;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !mem_ready;
          rsp_data_d  = (mem_ready && !mem_we_q) ? mem_rdata : 32'h0;
          rsp_low_d   = lat_low_q;
          rsp_size_d  = lat_size_q;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      c_resp:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= c_idle;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      lat_low_q   <= '0;
      lat_size_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_low_q   <= '0;
      rsp_size_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      lat_low_q   <= lat_low_d;
      lat_size_q  <= lat_size_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_low_q   <= rsp_low_d;
      rsp_size_q  <= rsp_size_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready    = (state_q == c_idle);
  assign mem_valid    = mem_valid_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_low_addr = rsp_low_q;
  assign rsp_size     = rsp_size_q;
  assign rsp_err      = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
// ============================================================================
// tb_lsu_bus_ctrl : directed and randomized checks against a request-level model.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_bus_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_low_addr;
  logic [2:0]  rsp_size;
  logic        rsp_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  int          last_nbus;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_low_addr(rsp_low_addr),
    .rsp_size(rsp_size), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input bit we, input logic [2:0] sz, input logic [1:0] off);
    if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b0;
    if (we && sz >= 3'd4) return 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (sz[1:0] == 2'd1 && off == 2'd3) return 1'b0;
    if (sz[1:0] == 2'd2 && off != 2'd0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [1:0] off);
    int nbytes;
    int mask;
    if (sz[1:0] == 2'd2) return 4'hF;
    nbytes = (sz[1:0] == 2'd0) ? 1 : 2;
    mask = ((1 << nbytes) - 1) << off;
    return 4'(mask & 15);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [1:0] off,
                                              input logic [31:0] wd);
    logic [63:0] wide;
    if (sz[1:0] == 2'd2) return wd;
    wide = {32'h0, wd} * (64'd1 << (8 * off));
    return wide[31:0];
  endfunction

  // Starts and ends at #1 after a rising edge with the controller idle.
  task automatic do_req(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int wait_n, input logic [31:0] rd);
    bit          lg;
    bit          err;
    bit          done;
    int          nbus;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    lg  = model_legal(we, sz, addr[1:0]);
    ebe = model_be(sz, addr[1:0]);
    ewd = model_wdata(sz, addr[1:0], wd);
    check_val("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    nbus = 0;
    if (!lg) begin
      check_val("ill_mem_valid", mem_valid, 0);
      check_val("ill_rsp_valid", rsp_valid, 1);
      check_val("ill_rsp_err", rsp_err, 1);
      check_val("ill_rsp_data", rsp_data, 0);
      check_val("ill_low_addr", rsp_low_addr, addr[1:0]);
      check_val("ill_size", rsp_size, sz);
      check_val("ill_req_ready", req_ready, 0);
    end else begin
      done = 1'b0;
      err  = 1'b0;
      while (!done) begin
        nbus++;
        check_val("bus_mem_valid", mem_valid, 1);
        check_val("bus_mem_addr", mem_addr, {addr[31:2], 2'b00});
        check_val("bus_mem_be", mem_be, ebe);
        check_val("bus_mem_we", mem_we, we);
        if (we) check_val("bus_mem_wdata", mem_wdata, ewd);
        check_val("bus_rsp_valid", rsp_valid, 0);
        check_val("bus_req_ready", req_ready, 0);
        last_be = mem_be;
        last_wd = mem_wdata;
        mem_ready = (nbus == wait_n + 1);
        mem_rdata = mem_ready ? rd : $urandom;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (nbus == wait_n + 1) begin
          done = 1'b1;
        end else if (nbus == T) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      check_val("rsp_mem_valid", mem_valid, 0);
      check_val("rsp_valid", rsp_valid, 1);
      check_val("rsp_err", rsp_err, err);
      check_val("rsp_data", rsp_data, (err || we) ? 32'h0 : rd);
      check_val("rsp_low_addr", rsp_low_addr, addr[1:0]);
      check_val("rsp_size", rsp_size, sz);
      check_val("rsp_req_ready", req_ready, 0);
    end
    last_nbus = nbus;
    @(posedge clk); #1;
    check_val("post_rsp_valid", rsp_valid, 0);
    check_val("post_mem_valid", mem_valid, 0);
    check_val("post_low_hold", rsp_low_addr, addr[1:0]);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    last_be = 4'h0; last_wd = 32'h0; last_nbus = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_mem_valid", mem_valid, 0);
    check_val("rst_mem_be", mem_be, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234);
    check_val("lb_be", last_be, 4'b1000);
    do_req(1'b1, 3'b001, 32'h0000_2001, 32'h0000_ABCD, 0, 32'h0);
    check_val("sh_be", last_be, 4'b0110);
    check_val("sh_wdata", last_wd, 32'h00AB_CD00);
    do_req(1'b0, 3'b010, 32'h0000_3000, 32'h0, 100, 32'h1111_2222);
    check_val("to_cycles", last_nbus, T);
    do_req(1'b0, 3'b010, 32'h0000_3000, 32'h0, T - 1, 32'h3333_4444);
    do_req(1'b0, 3'b010, 32'h0000_3002, 32'h0, 1, 32'h5555_6666);
`ifdef MISALIGN_TRAP_EN
    check_val("lw_mis_nobus", last_nbus, 0);
`else
    check_val("lw_mis_bus", last_be, 4'b1111);
`endif
    do_req(1'b1, 3'b100, 32'h0000_3000, 32'hFFFF_FFFF, 0, 32'h0);
    check_val("sbu_nobus", last_nbus, 0);
    do_req(1'b0, 3'b001, 32'h0000_3003, 32'h0, 0, 32'h7777_8888);

    // Reset while a load waits on the bus.
    req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h0000_5004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("rb_mem_valid", mem_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("rb_mem_valid_drop", mem_valid, 0);
    check_val("rb_rsp_valid", rsp_valid, 0);
    check_val("rb_req_ready", req_ready, 1);
    @(posedge clk); #1;
    check_val("rb_rsp_valid2", rsp_valid, 0);
    check_val("rb_mem_valid2", mem_valid, 0);

    do_req(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 0, 32'h0);
    check_val("sw_wdata", last_wd, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 32'h1234_5678);
    do_req(1'b1, 3'b000, 32'h0000_4002, 32'h0000_00A5, 1, 32'h0);
    check_val("sb_wdata", last_wd, 32'h00A5_0000);

    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, T + 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store bus controller sitting directly upstream of the load byte/halfword extraction stage. It accepts one memory request at a time from the execute stage and drives a word-addressed data-memory bus with byte enables and wait-state handshake. For loads it returns the raw 32-bit word plus the low two address bits and the access size, which the extraction stage needs. For stores it returns a completion acknowledge.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUS waiting for mem_ready before an error response; legal range 1..65535
TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  execute stage presents a request
req_ready  output  1  controller accepts the request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
mem_valid  output  1  bus request active
mem_ready  input  1  memory completes the access this cycle
mem_we  output  1  bus write strobe
mem_addr  output  32  word address, req_addr with bits [1:0] forced to 00
mem_be  output  4  byte enables
mem_wdata  output  32  lane-shifted store data
mem_rdata  input  32  read word, sampled when mem_valid & mem_ready
rsp_valid  output  1  one-cycle response pulse
rsp_data  output  32  raw read word for loads; 0 for stores and errors
rsp_low_addr  output  2  req_addr[1:0] of the completed request
rsp_size  output  3  req_size of the completed request
rsp_err  output  1  access failed: timeout, illegal size, or misaligned (macro-enabled)

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; all outputs 0 except req_ready=1 from the following cycle. A reset during BUS drops mem_valid at that edge and produces no response.
- FSM: IDLE -> BUS when req_valid & req_ready and the request is legal. IDLE -> RESP (err) on an illegal request. BUS -> RESP on mem_ready, or on timeout. RESP -> IDLE unconditionally.
- Request capture: on acceptance, latch we/size/addr/wdata. mem_* are registered and driven from the next cycle. They hold stable while mem_valid & !mem_ready.
- Legality: size 011/110/111 is illegal. For stores, 100/101 is also illegal. An illegal request issues no bus cycle; RESP follows with rsp_err=1.
- Byte enables (loads and stores alike): B/BU gives 4'b0001<<a[1:0]. H/HU gives 4'b0011<<a[1:0]. W gives 4'b1111. An H at offset 11 truncates to 4'b1000.
- Store data: mem_wdata = req_wdata << (8*a[1:0]) for B/H; unshifted for W.
- Latency: accept at edge 0; mem_valid high from edge 0 output. If mem_ready is sampled high at edge k, then mem_valid=0 and rsp_valid=1 for the cycle after edge k, with rsp_data = mem_rdata sampled at edge k. Zero-wait memory gives request-to-response of 2 cycles.
- Timeout: the counter clears on entry to BUS and increments each BUS cycle without mem_ready. When count reaches TIMEOUT_CYCLES, deassert mem_valid and go to RESP with rsp_err=1, rsp_data=0. If mem_ready and the terminal count coincide, mem_ready wins (no error).
- RESP: rsp_valid=1 for exactly one cycle. rsp_low_addr and rsp_size hold the latched values until the next response.
- Throughput: one request per 3 cycles minimum; req_ready=0 in BUS and RESP.
- mem_rdata is ignored outside mem_valid & mem_ready.

Optional Feature:
- MISALIGN_TRAP_EN defined: H/HU at a[1:0]=11, or W at a[1:0]!=00, is illegal. No bus cycle is issued; RESP follows with rsp_err=1. H at offset 01 remains legal because it stays within one word.
- Not defined: such accesses go to the bus with the truncated enables above; rsp_err=0. The downstream stage owns the result.

Test Plan:
- LB addr 0x0000_1003, mem_ready after 2 wait cycles, mem_rdata 0x80FF_1234 -> mem_addr 0x0000_1000, mem_be 1000, mem_we 0; rsp_valid 1 cycle after ready; rsp_data 0x80FF_1234, rsp_low_addr 11, rsp_size 000, rsp_err 0.
- SH addr 0x0000_2001, wdata 0x0000_ABCD, zero-wait -> mem_we 1, mem_be 0110, mem_wdata 0x00AB_CD00; rsp_valid 2 cycles after accept, rsp_data 0.
- TIMEOUT_CYCLES=4, LW 0x0000_3000, mem_ready held 0 -> mem_valid high exactly 4 cycles then low; rsp_err 1, rsp_data 0; ready=1 on the terminal cycle gives rsp_err 0.
- LW 0x0000_3002 with MISALIGN_TRAP_EN -> mem_valid never asserts, rsp_err 1 next cycle. Without the macro -> bus access with be 1111, rsp_err 0. Also store size 100 -> rsp_err 1, no bus.
- rst_n=0 for one edge while in BUS -> mem_valid 0 after that edge, no rsp_valid, req_ready 1 next cycle. Then back-to-back SW/LW complete in order with correct lanes.
